// File: rtl/vga_plot_arbiter.sv
// Round-robin share of the VGA pixel port among N_REQ drawing engines, plus a full-frame clear sweep.
// Pixel appears one cycle after its grant; requesters hold req until granted, and a clear holds off every grant.
module vga_plot_arbiter #(
  parameter int          N_REQ        = 2,
  parameter int          X_MAX        = 159,
  parameter int          Y_MAX        = 119,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_x,
  input  logic [7*N_REQ-1:0]   req_y,
  input  logic [3*N_REQ-1:0]   req_colour,
  output logic [N_REQ-1:0]     gnt,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 dropped,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 vga_resetn
);

  localparam int         PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            dropped_q, dropped_d;
  logic            busy_q, busy_d;
  logic            vga_resetn_q;

  logic            hit;
  logic [PW-1:0]   sel;
  logic [7:0]      sel_x;
  logic [6:0]      sel_y;
  logic [2:0]      sel_colour;
  int              idx;

  // First asserted request at or after the pointer, wrapping to 0.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = PW'(idx);
      end
    end
    sel_x      = req_x[8*int'(sel) +: 8];
    sel_y      = req_y[7*int'(sel) +: 7];
    sel_colour = req_colour[3*int'(sel) +: 3];
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    dropped_d = 1'b0;
    busy_d    = busy_q;
    gnt       = '0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d  = CLEAR;
          busy_d   = 1'b1;
          x_d      = '0;
          y_d      = '0;
          colour_d = CLEAR_COLOUR;
          plot_d   = 1'b1;
        end else if (hit) begin
          gnt[sel]  = resetn;
          x_d       = sel_x;
          y_d       = sel_y;
          colour_d  = sel_colour;
          plot_d    = (sel_x <= XM) && (sel_y <= YM);
          dropped_d = !((sel_x <= XM) && (sel_y <= YM));
          rr_d      = (int'(sel) == N_REQ - 1) ? '0 : sel + PW'(1);
        end
      end
      CLEAR: begin
        // The last pixel is already on the outputs: hand the port back next edge.
        if (x_q == XM && y_q == YM) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          plot_d   = 1'b1;
          colour_d = CLEAR_COLOUR;
          if (x_q == XM) begin
            x_d = '0;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      dropped_q    <= 1'b0;
      busy_q       <= 1'b0;
      vga_resetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      dropped_q    <= dropped_d;
      busy_q       <= busy_d;
      vga_resetn_q <= 1'b1;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign dropped    = dropped_q;
  assign clear_busy = busy_q;
  assign vga_resetn = vga_resetn_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed + randomized bench for vga_plot_arbiter against a pixel-index reference model.
module tb_vga_plot_arbiter;

  localparam int NR   = 2;
  localparam int NPIX = 160 * 120;

  logic            CLOCK_50;
  logic            resetn;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_x;
  logic [7*NR-1:0] req_y;
  logic [3*NR-1:0] req_colour;
  logic [NR-1:0]   gnt;
  logic            clear_req;
  logic            clear_busy;
  logic            dropped;
  logic [7:0]      x;
  logic [6:0]      y;
  logic [2:0]      colour;
  logic            plot;
  logic            vga_resetn;

  vga_plot_arbiter #(.N_REQ(NR)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .gnt        (gnt),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .dropped    (dropped),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .vga_resetn (vga_resetn)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: expected registered outputs, pointer, clear progress.
  int         m_rr;
  bit         m_clr;
  int         m_cnt;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  logic       m_plot, m_drop, m_busy, m_vr;
  logic [NR-1:0] last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_clr = 0; m_cnt = 0;
    m_x = '0; m_y = '0; m_c = '0;
    m_plot = 0; m_drop = 0; m_busy = 0; m_vr = 0;
    last_gnt = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] px,
                         input logic [6:0] py, input logic [2:0] pc);
    req[i]              = v;
    req_x[8*i +: 8]     = px;
    req_y[7*i +: 7]     = py;
    req_colour[3*i +: 3] = pc;
  endtask

  // One clock: inputs already driven just after a negedge.
  task automatic step();
    logic [NR-1:0] eg;
    int g;
    #1;
    eg = '0;
    if (m_clr) begin
      if (m_cnt < NPIX) begin
        m_x = 8'(m_cnt % 160); m_y = 7'(m_cnt / 160); m_c = 3'b000;
        m_plot = 1; m_drop = 0; m_busy = 1; m_cnt++;
      end else begin
        m_clr = 0; m_busy = 0; m_plot = 0; m_drop = 0;
      end
    end else if (clear_req) begin
      m_clr = 1; m_cnt = 1; m_x = '0; m_y = '0; m_c = 3'b000;
      m_plot = 1; m_drop = 0; m_busy = 1;
    end else begin
      g = -1;
      for (int k = 0; k < NR; k++)
        if (g < 0 && req[(m_rr + k) % NR]) g = (m_rr + k) % NR;
      if (g >= 0) begin
        eg[g]  = 1'b1;
        m_x    = req_x[8*g +: 8];
        m_y    = req_y[7*g +: 7];
        m_c    = req_colour[3*g +: 3];
        m_plot = (m_x < 160) && (m_y < 120);
        m_drop = !m_plot;
        m_rr   = (g + 1) % NR;
      end else begin
        m_plot = 0; m_drop = 0;
      end
    end
    last_gnt = eg;
    chk("gnt", 32'(gnt), 32'(eg));
    @(posedge CLOCK_50);
    #1;
    m_vr = 1;
    chk("x", 32'(x), 32'(m_x));
    chk("y", 32'(y), 32'(m_y));
    chk("colour", 32'(colour), 32'(m_c));
    chk("plot", 32'(plot), 32'(m_plot));
    chk("dropped", 32'(dropped), 32'(m_drop));
    chk("clear_busy", 32'(clear_busy), 32'(m_busy));
    chk("vga_resetn", 32'(vga_resetn), 32'(m_vr));
    @(negedge CLOCK_50);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'(0));
    chk({tag, "_plot"}, 32'(plot), 32'(0));
    chk({tag, "_busy"}, 32'(clear_busy), 32'(0));
    chk({tag, "_dropped"}, 32'(dropped), 32'(0));
    chk({tag, "_x"}, 32'(x), 32'(0));
    chk({tag, "_y"}, 32'(y), 32'(0));
    chk({tag, "_colour"}, 32'(colour), 32'(0));
    chk({tag, "_vga_resetn"}, 32'(vga_resetn), 32'(0));
  endtask

  initial begin
    int busy_cnt;
    int plot_cnt;
    resetn = 1'b1; req = '0; req_x = '0; req_y = '0; req_colour = '0; clear_req = 1'b0;
    model_reset();

    // Reset asserted with requests pending: no grant, all outputs at reset values.
    #1 resetn = 1'b0;
    set_req(0, 1'b1, 8'd33, 7'd44, 3'd6);
    set_req(1, 1'b1, 8'd55, 7'd66, 3'd1);
    #2 chk_reset_outputs("rst");
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1; req = '0;
    repeat (3) step();

    // Single pixel from requester 0.
    set_req(0, 1'b1, 8'd10, 7'd20, 3'b101);
    step();
    req = '0;
    step();

    // Both requesters held four cycles: alternating grants.
    set_req(0, 1'b1, 8'd1, 7'd2, 3'd3);
    set_req(1, 1'b1, 8'd100, 7'd110, 3'd4);
    repeat (4) step();
    req = '0;
    step();

    // Out-of-range x from requester 1.
    set_req(1, 1'b1, 8'd160, 7'd5, 3'd7);
    step();
    req = '0;
    set_req(0, 1'b1, 8'd159, 7'd120, 3'd2);
    step();
    req = '0;
    step();

    // Full clear with a competing request held off until the sweep ends.
    set_req(0, 1'b1, 8'd7, 7'd8, 3'd2);
    clear_req = 1'b1;
    busy_cnt = 0; plot_cnt = 0;
    step();
    busy_cnt += int'(clear_busy); plot_cnt += int'(plot);
    for (int i = 0; i < NPIX + 10 && m_clr; i++) begin
      clear_req = 1'($urandom_range(0, 1));
      step();
      busy_cnt += int'(clear_busy); plot_cnt += int'(plot);
    end
    clear_req = 1'b0;
    chk("clear_busy_cycles", 32'(busy_cnt), 32'(NPIX));
    chk("clear_plot_cycles", 32'(plot_cnt), 32'(NPIX));
    step();
    req = '0;
    step();

    // Reset in the middle of a clear sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (4999) step();
    set_req(0, 1'b1, 8'd12, 7'd34, 3'd5);
    resetn = 1'b0;
    #1 chk_reset_outputs("midclr");
    model_reset();
    @(negedge CLOCK_50);
    resetn = 1'b1;
    step();
    req = '0;
    repeat (2) step();

    // Randomized traffic; a request is held until its grant is seen.
    for (int i = 0; i < 500; i++) begin
      for (int r = 0; r < NR; r++) begin
        if (!(req[r] && !last_gnt[r]))
          set_req(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 170)),
                  7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
